// File: rtl/sccb_target.sv
// sccb_target: SCCB camera-side responder exposing a register write/read port
module sccb_target #(
  parameter logic [6:0] DEV_ID = 7'h21,
  parameter bit DRIVE_ACK = 1'b1
) (
  input  logic       sccb_clk,
  input  logic       sccb_reset_n,
  input  logic       sio_c_in,
  input  logic       sio_d_in,
  output logic       sio_d_oe,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy
);
  typedef enum logic [3:0] {
    IDLE, ID, ID_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT_STOP
  } state_t;
  state_t state, state_n;
  logic [1:0] c_sync, d_sync;
  logic c_h, d_h, c, d, rise, fall, start, stop, last, ack_ph, rw;
  logic [2:0] cnt;
  logic [6:0] sr;
  logic [7:0] rx_byte;
  assign c = c_sync[1];
  assign d = d_sync[1];
  assign rise = c & ~c_h;
  assign fall = ~c & c_h;
  assign start = c & c_h & d_h & ~d;
  assign stop = c & c_h & ~d_h & d;
  assign last = cnt == 3'd7;
  assign rx_byte = {sr, d};
  // two-flop synchronizers plus one history flop; idle bus reads high
  always_ff @(posedge sccb_clk or negedge sccb_reset_n)
    if (!sccb_reset_n) begin
      c_sync <= 2'b11;
      d_sync <= 2'b11;
      c_h <= 1'b1;
      d_h <= 1'b1;
    end else begin
      c_sync <= {c_sync[0], sio_c_in};
      d_sync <= {d_sync[0], sio_d_in};
      c_h <= c;
      d_h <= d;
    end
  // state register
  always_ff @(posedge sccb_clk or negedge sccb_reset_n)
    if (!sccb_reset_n) state <= IDLE;
    else state <= state_n;
  // next state: bus conditions override bit processing
  always_comb begin
    state_n = state;
    if (stop) state_n = IDLE;
    else if (start) state_n = ID;
    else
      case (state)
        ID: if (rise && last) state_n = rx_byte[7:1] == DEV_ID ? ID_ACK : WAIT_STOP;
        ID_ACK: if (fall && ack_ph) state_n = rw ? RDATA : SUB;
        SUB: if (rise && last) state_n = SUB_ACK;
        SUB_ACK, WDATA_ACK: if (fall && ack_ph) state_n = WDATA;
        WDATA: if (rise && last) state_n = WDATA_ACK;
        RDATA: if (fall && last) state_n = RACK;
        RACK: if (rise && d) state_n = WAIT_STOP; else if (fall && ack_ph) state_n = RDATA;
        default: ;
      endcase
  end
  // byte shifting, ack driving, pointer and register-port updates
  always_ff @(posedge sccb_clk or negedge sccb_reset_n)
    if (!sccb_reset_n) begin
      sio_d_oe <= 1'b0;
      wr_en <= 1'b0;
      wr_addr <= 8'd0;
      wr_data <= 8'd0;
      rd_addr <= 8'd0;
      busy <= 1'b0;
      cnt <= 3'd0;
      sr <= 7'd0;
      ack_ph <= 1'b0;
      rw <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (stop) begin
        sio_d_oe <= 1'b0;
        busy <= 1'b0;
        ack_ph <= 1'b0;
      end else if (start) begin
        sio_d_oe <= 1'b0;
        cnt <= 3'd0;
        ack_ph <= 1'b0;
      end else
        case (state)
          ID, SUB, WDATA:
            if (rise) begin
              sr <= rx_byte[6:0];
              cnt <= cnt + 3'd1;
              if (last && state == ID) begin
                busy <= rx_byte[7:1] == DEV_ID;
                rw <= d;
              end
              if (last && state == SUB) rd_addr <= rx_byte;
              if (last && state == WDATA) begin
                wr_en <= 1'b1;
                wr_addr <= rd_addr;
                wr_data <= rx_byte;
                rd_addr <= rd_addr + 8'd1;
              end
            end
          ID_ACK, SUB_ACK, WDATA_ACK:
            if (fall) begin
              ack_ph <= ~ack_ph;
              sio_d_oe <= ~ack_ph & DRIVE_ACK;
              if (ack_ph && state == ID_ACK && rw) begin
                sr <= rd_data[6:0];
                sio_d_oe <= ~rd_data[7];
              end
            end
          RDATA:
            if (fall) begin
              cnt <= cnt + 3'd1;
              sio_d_oe <= last ? 1'b0 : ~sr[6];
              sr <= {sr[5:0], 1'b0};
            end
          RACK:
            if (rise && !d) begin
              rd_addr <= rd_addr + 8'd1;
              ack_ph <= 1'b1;
            end else if (fall && ack_ph) begin
              ack_ph <= 1'b0;
              sr <= rd_data[6:0];
              sio_d_oe <= ~rd_data[7];
            end
          default: ;
        endcase
    end
endmodule

// File: tb/tb_sccb_target.sv
// tb_sccb_target: directed and randomized SCCB transactions against a transaction-level model
module tb_sccb_target;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m_c = 1'b1;
  logic m_d = 1'b1;
  logic bus_d, sio_d_oe, wr_en, busy;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
  logic [7:0] rom [256];
  logic [15:0] got [$];
  logic [15:0] exp_q [$];
  logic [7:0] txq [$];
  logic [7:0] ref_ptr = 8'd0;
  int gi = 0, n_cmp = 0, n_err = 0, oe_cnt = 0, busy_cnt = 0;

  assign bus_d = m_d & ~sio_d_oe;
  assign rd_data = rom[rd_addr];
  always #5 clk = ~clk;

  sccb_target #(.DEV_ID(7'h21), .DRIVE_ACK(1'b1)) dut (
    .sccb_clk(clk), .sccb_reset_n(rst_n), .sio_c_in(m_c), .sio_d_in(bus_d),
    .sio_d_oe(sio_d_oe), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
  );

  always @(negedge clk) begin
    if (wr_en) got.push_back({wr_addr, wr_data});
    if (sio_d_oe) oe_cnt++;
    if (busy) busy_cnt++;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic xfer_bit(input logic b, output logic g, output logic o);
    m_d = b;
    tick(6);
    m_c = 1'b1;
    tick(4);
    g = bus_d;
    o = sio_d_oe;
    tick(4);
    m_c = 1'b0;
    tick(2);
  endtask

  task automatic start_c();
    m_d = 1'b1;
    tick(6);
    m_c = 1'b1;
    tick(8);
    m_d = 1'b0;
    tick(8);
    m_c = 1'b0;
    tick(2);
  endtask

  task automatic stop_c();
    m_d = 1'b0;
    tick(6);
    m_c = 1'b1;
    tick(8);
    m_d = 1'b1;
    tick(8);
  endtask

  task automatic send_byte(input logic [7:0] v, output logic ack, output logic oe9);
    logic g, o;
    for (int i = 7; i >= 0; i--) xfer_bit(v[i], g, o);
    xfer_bit(1'b1, ack, oe9);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] v, output logic oe9);
    logic g, o;
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(1'b1, g, o);
      v[i] = g;
    end
    xfer_bit(nack, g, oe9);
  endtask

  task automatic write_txn(input logic do_stop);
    logic ack, o, match;
    logic [7:0] id;
    id = txq[0];
    match = id[7:1] == 7'h21 && !id[0];
    start_c();
    for (int i = 0; i < txq.size(); i++) begin
      send_byte(txq[i], ack, o);
      check($sformatf("ack byte%0d", i), 32'(ack), 32'(!match));
      check($sformatf("oe9 byte%0d", i), 32'(o), 32'(match));
    end
    if (match && txq.size() > 1) begin
      ref_ptr = txq[1];
      for (int i = 2; i < txq.size(); i++) begin
        exp_q.push_back({ref_ptr, txq[i]});
        ref_ptr = ref_ptr + 8'd1;
      end
    end
    if (do_stop) stop_c();
  endtask

  task automatic read_txn(input int n);
    logic ack, o;
    logic [7:0] v;
    start_c();
    send_byte(8'h43, ack, o);
    check("read id ack", 32'(ack), 32'd0);
    for (int k = 0; k < n; k++) begin
      recv_byte(k == n - 1, v, o);
      check($sformatf("read byte%0d @%0h", k, ref_ptr), 32'(v), 32'(rom[ref_ptr]));
      check($sformatf("released in master bit %0d", k), 32'(o), 32'd0);
      if (k != n - 1) ref_ptr = ref_ptr + 8'd1;
    end
    stop_c();
  endtask

  task automatic check_writes(input string tag);
    check({tag, " write count"}, 32'(got.size() - gi), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && gi + i < got.size(); i++)
      check($sformatf("%s write%0d", tag, i), 32'(got[gi+i]), 32'(exp_q[i]));
    gi = got.size();
    exp_q.delete();
  endtask

  initial begin
    logic g, o, ack;
    logic [7:0] id, v;
    int o0, b0, n;
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    rom[8'h0A] = 8'h76;
    rom[8'h30] = 8'h00;
    tick(3);
    check("reset oe", 32'(sio_d_oe), 32'd0);
    check("reset wr_en", 32'(wr_en), 32'd0);
    check("reset wr_addr", 32'(wr_addr), 32'd0);
    check("reset wr_data", 32'(wr_data), 32'd0);
    check("reset rd_addr", 32'(rd_addr), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick(4);

    b0 = busy_cnt;
    txq = '{8'h42, 8'h12, 8'h80};
    write_txn(1'b1);
    tick(4);
    check_writes("3phase");
    check("3phase busy seen", 32'(busy_cnt > b0), 32'd1);
    check("3phase busy after stop", 32'(busy), 32'd0);

    txq = '{8'h42, 8'h0A};
    write_txn(1'b1);
    read_txn(1);
    check("2phase rd_addr", 32'(rd_addr), 32'h0A);
    check_writes("2phase");

    o0 = oe_cnt;
    b0 = busy_cnt;
    txq = '{8'h60, 8'h12, 8'h55};
    write_txn(1'b1);
    check("mismatch oe cycles", 32'(oe_cnt - o0), 32'd0);
    check("mismatch busy cycles", 32'(busy_cnt - b0), 32'd0);
    check("mismatch rd_addr", 32'(rd_addr), 32'(ref_ptr));
    check_writes("mismatch");

    txq = '{8'h42, 8'hFE, 8'h11, 8'h22, 8'h33};
    write_txn(1'b1);
    check_writes("wrap");
    check("wrap rd_addr", 32'(rd_addr), 32'h01);

    txq = '{8'h42, 8'h05};
    write_txn(1'b0);
    for (int i = 0; i < 4; i++) xfer_bit(1'($urandom), g, o);
    read_txn(2);
    check("rstart rd_addr", 32'(rd_addr), 32'h06);
    check_writes("rstart");

    for (int it = 0; it < 6; it++) begin
      do id = 8'($urandom); while (id[7:1] == 7'h21);
      o0 = oe_cnt;
      txq = '{id, 8'($urandom), 8'($urandom)};
      write_txn(1'b1);
      check($sformatf("rand%0d mismatch oe", it), 32'(oe_cnt - o0), 32'd0);
      n = $urandom_range(1, 3);
      txq = '{8'h42, 8'($urandom)};
      for (int j = 0; j < n; j++) txq.push_back(8'($urandom));
      write_txn(1'b1);
      check_writes($sformatf("rand%0d", it));
      check($sformatf("rand%0d ptr after write", it), 32'(rd_addr), 32'(ref_ptr));
      txq = '{8'h42, 8'($urandom)};
      write_txn(1'b1);
      read_txn($urandom_range(1, 3));
      check($sformatf("rand%0d ptr after read", it), 32'(rd_addr), 32'(ref_ptr));
      check_writes($sformatf("rand%0d read", it));
    end

    txq = '{8'h42, 8'h30};
    write_txn(1'b1);
    check_writes("pre-reset");
    start_c();
    send_byte(8'h43, ack, o);
    check("pre-reset id ack", 32'(ack), 32'd0);
    xfer_bit(1'b1, g, o);
    check("pre-reset bit7", 32'(g), 32'd0);
    for (int i = 0; i < 20 && !sio_d_oe; i++) tick(1);
    check("pre-reset driving", 32'(sio_d_oe), 32'd1);
    check("pre-reset busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async release", 32'(sio_d_oe), 32'd0);
    m_c = 1'b1;
    m_d = 1'b1;
    tick(4);
    rst_n = 1'b1;
    ref_ptr = 8'd0;
    tick(2);
    check("post-reset busy", 32'(busy), 32'd0);
    check("post-reset rd_addr", 32'(rd_addr), 32'(ref_ptr));

    v = 8'($urandom);
    txq = '{8'h42, 8'h10, v};
    write_txn(1'b1);
    check_writes("recovery");
    check("recovery rd_addr", 32'(rd_addr), 32'h11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sccb_target.md
# sccb_target

Single-clock SCCB target (camera-side responder) for the camera debug build: the far end of the SCCB bus driven by `sccb_bridge`. It decodes start/stop, ID, sub-address and data phases from oversampled SIO_C/SIO_D and exposes a simple register write/read port. This lets `sccb_config` sequences be looped back and checked on-board, or in simulation, without a sensor attached.

## Interface
- `DEV_ID`, 7'h21, 7-bit device address; matches write ID 8'h42 and read ID 8'h43.
- `DRIVE_ACK`, 1, when 1 the target pulls SIO_D low in each write-phase "don't-care" (9th) bit.
- `sccb_clk` input 1 — block clock, at least 8× the SIO_C rate.
- `sccb_reset_n` input 1 — reset, asynchronous, active-low.
- `sio_c_in` input 1 — SIO_C from the pad, asynchronous.
- `sio_d_in` input 1 — SIO_D from the pad, asynchronous.
- `sio_d_oe` output 1 — 1 = pad drives SIO_D low (open-drain); 0 = released.
- `wr_en` output 1 — one-cycle register write strobe.
- `wr_addr` output 8 — write sub-address, valid with `wr_en`.
- `wr_data` output 8 — write data, valid with `wr_en`.
- `rd_addr` output 8 — current read pointer.
- `rd_data` input 8 — register contents at `rd_addr`, combinational from the owner.
- `busy` output 1 — 1 from an ID match until stop or ID-mismatch abort.

## Operation
- Input conditioning:
  - 2-flop synchronizer on each of `sio_c_in` and `sio_d_in`, plus one history flop each.
  - Edges are detected on synchronized values only.
- Bus condition detection:
  - Start: SIO_D falls while SIO_C is high.
  - Stop: SIO_D rises while SIO_C is high.
  - Start and stop take priority over data-bit processing in the same cycle.
- Bit handling:
  - Data bits are sampled on the SIO_C rising edge, MSB first.
  - `sio_d_oe` changes only on the SIO_C falling edge, except on stop, start or reset.
- States: IDLE, ID, ID_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT_STOP. A 3-bit counter tracks bit position within each byte.
- IDLE: start → ID, counter = 0.
- ID: after the 8th bit, compare ID[7:1] with `DEV_ID`.
  - Mismatch → WAIT_STOP; never drive the bus.
  - Match → ID_ACK, `busy` = 1; capture the R/W bit.
- ID_ACK:
  - On the falling edge that ends bit 8, assert `sio_d_oe` if `DRIVE_ACK`.
  - On the next falling edge, release it.
  - Then go to SUB if W, or RDATA if R. For R, load the shift register from `rd_data` and drive bit 7 (`sio_d_oe` = ~bit).
- SUB: after 8 bits, the sub-address is loaded into the pointer (`rd_addr`) → SUB_ACK. The pointer persists across stop, which gives SCCB 2-phase write semantics.
- SUB_ACK, WDATA_ACK: ack handling as in ID_ACK; then → WDATA.
- WDATA: after 8 bits:
  - `wr_en` pulses with `wr_addr` = pointer and `wr_data` = byte.
  - The pointer increments modulo 256 (0xFF → 0x00).
  - → WDATA_ACK.
- RDATA:
  - Shift out on each falling edge.
  - After bit 0's falling edge, release SIO_D → RACK.
- RACK: sample the master bit on the rising edge.
  - 1 (NA) → WAIT_STOP.
  - 0 → increment the pointer, reload the shift register from `rd_data` on the next falling edge, → RDATA.
- WAIT_STOP: ignore bits until stop or start.
- Any state:
  - Stop → IDLE, `sio_d_oe` = 0, `busy` = 0.
  - Start (repeated) → ID, counter = 0, `sio_d_oe` = 0.
  - A partial byte is discarded and no `wr_en` is issued.

## Timing
- Reset values: `sio_d_oe` = 0, `wr_en` = 0, `wr_addr` = 0, `wr_data` = 0, `rd_addr` = 0, `busy` = 0. Internal state = IDLE.
- Reset mid-transfer releases SIO_D immediately (asynchronous clear).
- Pad-to-decision latency: 3 `sccb_clk` cycles (2 sync + 1 edge).
- `sio_d_oe` updates 3 cycles after the physical SIO_C fall, which provides SIO_D hold time.
- `wr_en` is asserted 1 cycle after the edge detect of the 8th WDATA rising edge.
- `rd_data` is sampled in the cycle the falling edge is detected.
- Bus requirements: SIO_C high and low phases ≥ 4 `sccb_clk` cycles. SIO_D must be stable ≥ 4 cycles before the SIO_C rise.

## Test plan
- 3-phase write: start, 0x42, 0x12, 0x80, stop → exactly one `wr_en` with `wr_addr` = 0x12 and `wr_data` = 0x80; `sio_d_oe` = 1 during all three 9th bits; `busy` falls after stop.
- 2-phase write then 2-phase read: write 0x42, 0x0A, stop; read 0x43 with `rd_data` = 0x76 and master NA → `rd_addr` = 0x0A; SIO_D carries 0,1,1,1,0,1,1,0; SIO_D released in the NA bit; no `wr_en`.
- ID mismatch: start, 0x60, 0x12, 0x55, stop → `sio_d_oe` stays 0 throughout; no `wr_en`; `busy` stays 0.
- Burst write with wrap: 0x42, 0xFE, then data 0x11, 0x22, 0x33 → writes (0xFE,0x11), (0xFF,0x22), (0x00,0x33); final `rd_addr` = 0x01.
- Repeated start mid-byte: 0x42, 0x05, 4 data bits, start, then 0x43 with master ACK then NA → no write; two bytes read from addresses 0x05 and 0x06.
- Reset during RDATA while `sio_d_oe` = 1 → `sio_d_oe` = 0 in the same cycle; after reset, `busy` = 0 and `rd_addr` = 0x00.
